// File: rtl/idu_pipe_pkg.sv
// Shared constants for the decode stage: op-class bit indices, opcodes and fixed encodings.
package idu_pipe_pkg;

  localparam int unsigned OP_WIDTH = 12;

  typedef logic [OP_WIDTH-1:0] op_info_t;

  typedef enum logic [3:0] {
    OpLui    = 4'd0,
    OpAuipc  = 4'd1,
    OpJal    = 4'd2,
    OpJalr   = 4'd3,
    OpBranch = 4'd4,
    OpLoad   = 4'd5,
    OpStore  = 4'd6,
    OpAluI   = 4'd7,
    OpAluR   = 4'd8,
    OpAluIw  = 4'd9,
    OpAluRw  = 4'd10,
    OpSystem = 4'd11
  } op_idx_e;

  typedef enum logic [6:0] {
    OpcLui    = 7'b0110111,
    OpcAuipc  = 7'b0010111,
    OpcJal    = 7'b1101111,
    OpcJalr   = 7'b1100111,
    OpcBranch = 7'b1100011,
    OpcLoad   = 7'b0000011,
    OpcStore  = 7'b0100011,
    OpcAluI   = 7'b0010011,
    OpcAluR   = 7'b0110011,
    OpcAluIw  = 7'b0011011,
    OpcAluRw  = 7'b0111011,
    OpcSystem = 7'b1110011
  } opcode_e;

  localparam logic [31:0] InstrEcall  = 32'h0000_0073;
  localparam logic [31:0] InstrEbreak = 32'h0010_0073;

endpackage

// File: rtl/idu_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface idu_pipe_if
  import idu_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [XLEN-1:0]  out_imm;
  op_info_t         out_op_info;
  logic [2:0]       out_fun3;
  logic             out_alt;
  logic             out_ebreak;
  logic             out_illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_op_info,
           out_fun3, out_alt, out_ebreak, out_illegal, instr_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_op_info,
           out_fun3, out_alt, out_ebreak, out_illegal, instr_cnt
  );
endinterface

// File: rtl/idu_imm_gen.sv
// Immediate extraction: picks the format from the one-hot op class and sign-extends to XLEN.
module idu_imm_gen
  import idu_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:7]     instr_i,
  input  op_info_t        op_info_i,
  output logic [XLEN-1:0] imm_o
);
  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      op_info_i[OpLui], op_info_i[OpAuipc]:
        imm32 = {instr_i[31:12], 12'b0};
      op_info_i[OpJal]:
        imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      op_info_i[OpJalr], op_info_i[OpLoad], op_info_i[OpAluI], op_info_i[OpAluIw],
      op_info_i[OpSystem]:
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      op_info_i[OpBranch]:
        imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      op_info_i[OpStore]:
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      op_info_i[OpAluR], op_info_i[OpAluRw]:
        imm32 = '0;
      default:
        imm32 = '0;
    endcase
  end

  // Signed size cast sign-extends to XLEN.
  assign imm_o = XLEN'(imm32);
endmodule

// File: rtl/idu_pipe.sv
// Registered RV32I/RV64I decode stage with valid/ready output register, flush and hand-off count.
module idu_pipe
  import idu_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input logic       clk,
  input logic       rst_n,
  idu_pipe_if.slave bus
);
  localparam bit Xlen32 = (XLEN == 32);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    op_info_t        op_info;
    logic [2:0]      fun3;
    logic            alt;
    logic            ebreak;
    logic            illegal;
  } dec_t;

  logic [31:0]      instr;
  logic [2:0]       fun3;
  logic [6:0]       fun7;
  logic             shift_imm;
  op_info_t         op_info;
  logic             illegal;
  logic             alt;
  logic [XLEN-1:0]  imm;
  dec_t             dec_d, dec_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  assign instr     = bus.in_instr;
  assign fun3      = instr[14:12];
  assign fun7      = instr[31:25];
  assign shift_imm = (fun3 == 3'b001) || (fun3 == 3'b101);

  always_comb begin
    op_info = '0;
    illegal = 1'b0;
    alt     = 1'b0;
    case (instr[6:0])
      OpcLui:   op_info[OpLui]   = 1'b1;
      OpcAuipc: op_info[OpAuipc] = 1'b1;
      OpcJal:   op_info[OpJal]   = 1'b1;
      OpcJalr: begin
        op_info[OpJalr] = 1'b1;
        illegal         = (fun3 != 3'b000);
      end
      OpcBranch: begin
        op_info[OpBranch] = 1'b1;
        illegal           = fun3 inside {3'b010, 3'b011};
      end
      OpcLoad: begin
        op_info[OpLoad] = 1'b1;
        illegal         = (fun3 == 3'b111) || (Xlen32 && (fun3 inside {3'b011, 3'b110}));
      end
      OpcStore: begin
        op_info[OpStore] = 1'b1;
        illegal          = fun3[2] || (Xlen32 && (fun3 == 3'b011));
      end
      OpcAluI: begin
        op_info[OpAluI] = 1'b1;
        alt             = shift_imm & instr[30];
        // RV32 shift amounts are 5 bits; shamt[5] set has no meaning there.
        illegal         = Xlen32 && shift_imm && instr[25];
      end
      OpcAluR: begin
        op_info[OpAluR] = 1'b1;
        alt             = instr[30];
        illegal         = !((fun7 == 7'b0000000) ||
                            ((fun7 == 7'b0100000) && (fun3 inside {3'b000, 3'b101})));
      end
      OpcAluIw: begin
        op_info[OpAluIw] = 1'b1;
        alt              = shift_imm & instr[30];
        illegal          = Xlen32;
      end
      OpcAluRw: begin
        op_info[OpAluRw] = 1'b1;
        alt              = instr[30];
        illegal          = Xlen32;
      end
      OpcSystem: begin
        op_info[OpSystem] = 1'b1;
        illegal           = !((instr == InstrEcall) || (instr == InstrEbreak));
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      op_info = '0;
      alt     = 1'b0;
    end
  end

  idu_imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .instr_i  (instr[31:7]),
    .op_info_i(op_info),
    .imm_o    (imm)
  );

  always_comb begin
    dec_d         = '0;
    dec_d.pc      = bus.in_pc;
    dec_d.rs1     = instr[19:15];
    dec_d.rs2     = instr[24:20];
    dec_d.rd      = instr[11:7];
    dec_d.imm     = imm;
    dec_d.op_info = op_info;
    dec_d.fun3    = fun3;
    dec_d.alt     = alt;
    dec_d.ebreak  = (instr == InstrEbreak);
    dec_d.illegal = illegal;
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // A handshake completing in a flush cycle still counts.
      if (valid_q && bus.out_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (accept) begin
        dec_q <= dec_d;
      end
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = dec_q.pc;
  assign bus.out_rs1     = dec_q.rs1;
  assign bus.out_rs2     = dec_q.rs2;
  assign bus.out_rd      = dec_q.rd;
  assign bus.out_imm     = dec_q.imm;
  assign bus.out_op_info = dec_q.op_info;
  assign bus.out_fun3    = dec_q.fun3;
  assign bus.out_alt     = dec_q.alt;
  assign bus.out_ebreak  = dec_q.ebreak;
  assign bus.out_illegal = dec_q.illegal;
  assign bus.instr_cnt   = cnt_q;
endmodule
